// File: rtl/dcfifo_wr_arbiter_pkg.sv
// Shared helpers for the dual-clock FIFO write-side controller.
// Holds the size derivations, Gray decode and round-robin search.
package dcfifo_wr_arbiter_pkg;

  // Total capacity of the two-bank FIFO
  function automatic int calc_depth(input int len_log_a, input int len_log_b);
    return (1 << len_log_a) + (1 << len_log_b);
  endfunction

  // Occupancy counter width; two extra bits keep 2^CW above the total depth
  function automatic int calc_cw(input int len_log_a);
    return len_log_a + 2;
  endfunction

  // Gray to binary; callers zero-extend narrower codes, which decode unchanged
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // First set request at or after ptr, wrapping circularly over n requesters
  function automatic logic [2:0] rr_first(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input int n);
    logic found;
    int c;
    rr_first = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c = int'(ptr) + k;
      if (c >= n) c = c - n;
      if (k < n && !found && req[c[2:0]]) begin
        found = 1'b1;
        rr_first = c[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/dcfifo_wr_arbiter_if.sv
// Producer-side write bus: requests and data in, grants and FIFO write out.
interface dcfifo_wr_arbiter_if
  import dcfifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din_flat;
  logic [NREQ-1:0]    gnt;
  logic               enq;
  logic [DW-1:0]      fifo_din;

  modport master (output req, din_flat, input gnt, enq, fifo_din);
  modport slave  (input req, din_flat, output gnt, enq, fifo_din);
endinterface

// File: rtl/dcfifo_wr_arbiter_gray_sync_cnt.sv
// Two-flop synchronizer for a Gray-coded counter followed by binary decode.
// Kept generic so the read-side controller can reuse it for the write count.
module gray_sync_cnt
  import dcfifo_wr_arbiter_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          clr,
  input  logic [CW-1:0] gray,
  output logic [CW-1:0] bin
);
  logic [CW-1:0] s1;
  logic [CW-1:0] s2;

  // Two-stage capture of the foreign-domain Gray count
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      s1 <= '0;
      s2 <= '0;
    end else if (clr) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gray;
      s2 <= s1;
    end
  end

  assign bin = CW'(gray2bin(32'(s2)));
endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// Write-side controller for the two-bank dual-clock FIFO.
// Round-robin arbitration with bounded bursts, occupancy from the synced read count.
module dcfifo_wr_arbiter
  import dcfifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int DW        = 32,
  parameter int LEN_LOG_A = 12,
  parameter int LEN_LOG_B = 9,
  parameter int MAXBURST  = 4,
  localparam int DEPTH    = calc_depth(LEN_LOG_A, LEN_LOG_B),
  localparam int CW       = calc_cw(LEN_LOG_A)
) (
  input  logic                 WCLK,
  input  logic                 RST_X,
  input  logic                 WRST,
  dcfifo_wr_arbiter_if.slave   bus,
  input  logic [CW-1:0]        rcnt_gray,
  output logic [CW-1:0]        level,
  output logic                 full,
  output logic                 err
);
  localparam int BW = $clog2(MAXBURST + 1);

  logic [7:0]    req_pad;
  logic [2:0]    rr_ptr;
  logic [2:0]    owner;
  logic [2:0]    win;
  logic          owner_valid;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt_sync;
  logic          keep;
  logic          do_grant;

  assign req_pad = 8'(bus.req);

  gray_sync_cnt #(.CW(CW)) u_sync (
    .clk   (WCLK),
    .rst_x (RST_X),
    .clr   (WRST),
    .gray  (rcnt_gray),
    .bin   (rcnt_sync)
  );

  // Modulo subtraction stays correct across counter wrap; a stale read count only overestimates
  assign level = wcnt - rcnt_sync;
  assign full  = (level >= CW'(DEPTH));

  // Pick the winner: continue the current burst if allowed, else rotate from rr_ptr
  always_comb begin
    keep     = owner_valid && req_pad[owner] && (burst_cnt < BW'(MAXBURST));
    do_grant = (|bus.req) && !full && !WRST && RST_X;
    win      = keep ? owner : rr_first(req_pad, rr_ptr, NREQ);
    bus.gnt  = '0;
    if (do_grant) bus.gnt = NREQ'(1) << win;
  end

  // Write count, registered FIFO write port and burst/rotation state
  always_ff @(posedge WCLK or negedge RST_X) begin
    if (!RST_X) begin
      wcnt         <= '0;
      bus.enq      <= 1'b0;
      bus.fifo_din <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      owner_valid  <= 1'b0;
      burst_cnt    <= '0;
    end else if (WRST) begin
      wcnt         <= '0;
      bus.enq      <= 1'b0;
      bus.fifo_din <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      owner_valid  <= 1'b0;
      burst_cnt    <= '0;
    end else if (do_grant) begin
      wcnt         <= wcnt + CW'(1);
      bus.enq      <= 1'b1;
      bus.fifo_din <= bus.din_flat[int'(win)*DW +: DW];
      if (keep) begin
        burst_cnt <= burst_cnt + BW'(1);
      end else begin
        owner       <= win;
        owner_valid <= 1'b1;
        burst_cnt   <= BW'(1);
        rr_ptr      <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
      end
    end else begin
      bus.enq <= 1'b0;
      if (!full && owner_valid && !req_pad[owner]) owner_valid <= 1'b0;
    end
  end

  // Sticky overrun flag: the read side has consumed more than was written
  always_ff @(posedge WCLK or negedge RST_X) begin
    if (!RST_X) begin
      err <= 1'b0;
    end else if (WRST) begin
      err <= 1'b0;
    end else if (level > CW'(DEPTH)) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// Directed bench for the FIFO write arbiter (NREQ=3, DW=8, DEPTH=12, CW=5, MAXBURST=2).
module tb_dcfifo_wr_arbiter;
  logic       WCLK;
  logic       RST_X;
  logic       WRST;
  logic [4:0] rcnt_gray;
  logic [4:0] level;
  logic       full;
  logic       err;
  int         checks;
  int         errors;

  typedef struct {
    logic [2:0] req;
    logic [4:0] rcnt;
    logic [2:0] gnt;
    logic       enq;
    logic [7:0] dout;
    logic [4:0] lvl;
    logic       full;
    logic       err;
  } vec_t;

  vec_t tbl[21];

  dcfifo_wr_arbiter_if #(.NREQ(3), .DW(8)) bus ();

  dcfifo_wr_arbiter #(
    .NREQ(3), .DW(8), .LEN_LOG_A(3), .LEN_LOG_B(2), .MAXBURST(2)
  ) dut (
    .WCLK      (WCLK),
    .RST_X     (RST_X),
    .WRST      (WRST),
    .bus       (bus),
    .rcnt_gray (rcnt_gray),
    .level     (level),
    .full      (full),
    .err       (err)
  );

  // Free-running write clock
  initial begin
    WCLK = 1'b0;
    forever #5 WCLK = ~WCLK;
  end

  function automatic vec_t mk(input logic [2:0] req, input logic [4:0] rcnt,
                              input logic [2:0] gnt, input logic enq,
                              input logic [7:0] dout, input logic [4:0] lvl,
                              input logic fl, input logic er);
    vec_t v;
    v.req = req; v.rcnt = rcnt; v.gnt = gnt; v.enq = enq;
    v.dout = dout; v.lvl = lvl; v.full = fl; v.err = er;
    return v;
  endfunction

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge WCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int r);
    bus.req      = v.req;
    rcnt_gray    = v.rcnt;
    bus.din_flat = {8'h70 + 8'(r), 8'h40 + 8'(r), 8'h10 + 8'(r)};
    #1;
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    WRST = 1'b0;
    bus.req = '0;
    bus.din_flat = '0;
    rcnt_gray = '0;
    tick();
    tick();
    RST_X = 1'b1;
  endtask

  initial begin
    logic [4:0] w;
    checks = 0;
    errors = 0;

    // Round-robin until full, then drain two entries and resume
    tbl[0]  = mk(3'b111, 5'd0, 3'b001, 1'b0, 8'h00, 5'd0,  1'b0, 1'b0);
    tbl[1]  = mk(3'b111, 5'd0, 3'b001, 1'b1, 8'h10, 5'd1,  1'b0, 1'b0);
    tbl[2]  = mk(3'b111, 5'd0, 3'b010, 1'b1, 8'h11, 5'd2,  1'b0, 1'b0);
    tbl[3]  = mk(3'b111, 5'd0, 3'b010, 1'b1, 8'h42, 5'd3,  1'b0, 1'b0);
    tbl[4]  = mk(3'b111, 5'd0, 3'b100, 1'b1, 8'h43, 5'd4,  1'b0, 1'b0);
    tbl[5]  = mk(3'b111, 5'd0, 3'b100, 1'b1, 8'h74, 5'd5,  1'b0, 1'b0);
    tbl[6]  = mk(3'b111, 5'd0, 3'b001, 1'b1, 8'h75, 5'd6,  1'b0, 1'b0);
    tbl[7]  = mk(3'b111, 5'd0, 3'b001, 1'b1, 8'h16, 5'd7,  1'b0, 1'b0);
    tbl[8]  = mk(3'b111, 5'd0, 3'b010, 1'b1, 8'h17, 5'd8,  1'b0, 1'b0);
    tbl[9]  = mk(3'b111, 5'd0, 3'b010, 1'b1, 8'h48, 5'd9,  1'b0, 1'b0);
    tbl[10] = mk(3'b111, 5'd0, 3'b100, 1'b1, 8'h49, 5'd10, 1'b0, 1'b0);
    tbl[11] = mk(3'b111, 5'd0, 3'b100, 1'b1, 8'h7A, 5'd11, 1'b0, 1'b0);
    tbl[12] = mk(3'b111, 5'd0, 3'b000, 1'b1, 8'h7B, 5'd12, 1'b1, 1'b0);
    tbl[13] = mk(3'b111, 5'd0, 3'b000, 1'b0, 8'h7B, 5'd12, 1'b1, 1'b0);
    tbl[14] = mk(3'b000, 5'd1, 3'b000, 1'b0, 8'h7B, 5'd12, 1'b1, 1'b0);
    tbl[15] = mk(3'b000, 5'd1, 3'b000, 1'b0, 8'h7B, 5'd12, 1'b1, 1'b0);
    tbl[16] = mk(3'b000, 5'd3, 3'b000, 1'b0, 8'h7B, 5'd11, 1'b0, 1'b0);
    tbl[17] = mk(3'b000, 5'd3, 3'b000, 1'b0, 8'h7B, 5'd11, 1'b0, 1'b0);
    tbl[18] = mk(3'b000, 5'd3, 3'b000, 1'b0, 8'h7B, 5'd10, 1'b0, 1'b0);
    tbl[19] = mk(3'b010, 5'd3, 3'b010, 1'b0, 8'h7B, 5'd10, 1'b0, 1'b0);
    tbl[20] = mk(3'b000, 5'd3, 3'b000, 1'b1, 8'h53, 5'd11, 1'b0, 1'b0);

    do_reset();
    for (int r = 0; r < 21; r++) begin
      applyStimulus(tbl[r], r);
      checkOutput($sformatf("row%0d gnt", r),   32'(bus.gnt),      32'(tbl[r].gnt));
      checkOutput($sformatf("row%0d enq", r),   32'(bus.enq),      32'(tbl[r].enq));
      checkOutput($sformatf("row%0d dout", r),  32'(bus.fifo_din), 32'(tbl[r].dout));
      checkOutput($sformatf("row%0d level", r), 32'(level),        32'(tbl[r].lvl));
      checkOutput($sformatf("row%0d full", r),  32'(full),         32'(tbl[r].full));
      checkOutput($sformatf("row%0d err", r),   32'(err),          32'(tbl[r].err));
      tick();
    end

    // Asynchronous reset mid-stream, then the first request after release
    bus.req = 3'b111;
    RST_X = 1'b0;
    rcnt_gray = '0;
    #1;
    checkOutput("rst gnt",   32'(bus.gnt), 32'd0);
    checkOutput("rst enq",   32'(bus.enq), 32'd0);
    checkOutput("rst level", 32'(level),   32'd0);
    checkOutput("rst full",  32'(full),    32'd0);
    checkOutput("rst err",   32'(err),     32'd0);
    tick();
    RST_X = 1'b1;
    bus.req = 3'b100;
    bus.din_flat = {8'h99, 8'h55, 8'h11};
    #1;
    checkOutput("post-rst gnt", 32'(bus.gnt), 32'b100);
    tick();
    bus.req = 3'b000;
    #1;
    checkOutput("post-rst enq",  32'(bus.enq),      32'd1);
    checkOutput("post-rst dout", 32'(bus.fifo_din), 32'h99);

    // Wrap: read count follows three behind while wcnt wraps through 31 -> 0
    do_reset();
    bus.req = 3'b001;
    bus.din_flat = {8'h03, 8'h02, 8'h01};
    w = 5'd0;
    for (int c = 0; c < 43; c++) begin
      if (c >= 3) rcnt_gray = to_gray(w - 5'd1);
      #1;
      if (c >= 5) checkOutput($sformatf("wrap c%0d level", c), 32'(level), 32'd3);
      tick();
      w = w + 5'd1;
    end
    checkOutput("wrap err", 32'(err), 32'd0);

    // Lone requester keeps being granted across burst expiry
    do_reset();
    bus.req = 3'b010;
    bus.din_flat = {8'h33, 8'h22, 8'h11};
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("single c%0d gnt", c), 32'(bus.gnt), 32'b010);
      tick();
    end
    checkOutput("single level", 32'(level), 32'd6);

    // Synchronous clear mid-burst cancels the grant and the next write
    WRST = 1'b1;
    #1;
    checkOutput("wrst gnt", 32'(bus.gnt), 32'd0);
    tick();
    WRST = 1'b0;
    bus.req = 3'b000;
    #1;
    checkOutput("wrst enq",   32'(bus.enq), 32'd0);
    checkOutput("wrst level", 32'(level),   32'd0);

    // Overrun: read count jumps past the write count
    do_reset();
    bus.req = 3'b001;
    tick();
    tick();
    bus.req = 3'b000;
    rcnt_gray = to_gray(5'd5);
    tick();
    tick();
    #1;
    checkOutput("ovr level", 32'(level), 32'd29);
    checkOutput("ovr full",  32'(full),  32'd1);
    checkOutput("ovr err0",  32'(err),   32'd0);
    tick();
    checkOutput("ovr err1", 32'(err), 32'd1);
    rcnt_gray = to_gray(5'd2);
    tick();
    tick();
    tick();
    checkOutput("ovr sticky level", 32'(level), 32'd0);
    checkOutput("ovr sticky err",   32'(err),   32'd1);
    WRST = 1'b1;
    rcnt_gray = '0;
    tick();
    WRST = 1'b0;
    #1;
    checkOutput("ovr clr err",   32'(err),   32'd0);
    checkOutput("ovr clr level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
